updown_counter: RTL and testbench

Parametrised successor to the team's 4-bit enable counter: an up/down counter with configurable width, modulus, prescaler and wrap/saturate mode, plus synchronous parallel load. It also provides a terminal-count pulse and a sticky overflow flag. It sits in the same clock domain as the logic that drives `enable`, and is used as a general event/interval counter and as a timebase divider.

---
 rtl/updown_counter.sv | 108 ++++++++++
 tb/tb_updown_counter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter.sv
// updown_counter
//   Up/down counter with configurable width, modulus (0..MAX_COUNT),
//   prescaler and wrap/saturate boundary behaviour, plus synchronous
//   parallel load, a one-cycle terminal-count pulse and a sticky overflow.
//
// Parameters:
//   WIDTH      counter width in bits (>= 2)
//   MAX_COUNT  highest count value (<= 2**WIDTH-1)
//   SATURATE   0 = wrap at the boundary, 1 = hold at the boundary
//   PRESCALE   enabled cycles per count step (>= 1)
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous active-high reset
//   enable       count qualifier; low freezes counter and prescaler
//   up_down      direction, 1 = up, 0 = down (sampled on step cycles)
//   load         synchronous parallel load (priority over stepping)
//   load_value   value to load, clamped to MAX_COUNT
//   clear_ovf    clears the sticky overflow flag (a same-cycle set wins)
//   counter_out  current count
//   tc           terminal-count pulse, high the cycle after a boundary step
//   overflow     sticky boundary-crossing flag
module updown_counter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_COUNT = (1 << WIDTH) - 1,
  parameter int unsigned SATURATE  = 0,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_ovf,
  output logic [WIDTH-1:0] counter_out,
  output logic             tc,
  output logic             overflow
);

  localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_COUNT);
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step;
  logic             at_boundary;

  always_comb begin
    count_d     = count_q;
    ps_d        = ps_q;
    tc_d        = 1'b0;
    ovf_d       = ovf_q & ~clear_ovf;
    step        = 1'b0;
    at_boundary = 1'b0;

    if (load) begin
      count_d = (load_value > MAX_C) ? MAX_C : load_value;
      ps_d    = '0;
    end else if (enable) begin
      step = (ps_q == PS_LAST);
      ps_d = step ? '0 : ps_q + 1'b1;
      if (step) begin
        if (up_down) begin
          at_boundary = (count_q == MAX_C);
          if (!at_boundary)
            count_d = count_q + 1'b1;
          else
            count_d = (SATURATE != 0) ? MAX_C : '0;
        end else begin
          at_boundary = (count_q == '0);
          if (!at_boundary)
            count_d = count_q - 1'b1;
          else
            count_d = (SATURATE != 0) ? '0 : MAX_C;
        end
      end
    end

    // A boundary step sets overflow even when clear_ovf is asserted.
    if (at_boundary) begin
      tc_d  = 1'b1;
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      ps_q    <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ps_q    <= ps_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign counter_out = count_q;
  assign tc          = tc_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_updown_counter.sv
// Bench for updown_counter: four differently parameterised instances share
// one set of inputs. A behavioural model per instance checks every cycle;
// directed tables/sequences check the corner cases with constant expectations.
module tb_updown_counter;

  logic       clock = 1'b0;
  logic       reset, enable, up_down, load, clear_ovf;
  logic [7:0] lv;
  logic [3:0] c0, c2, c3;
  logic [7:0] c1;
  logic [3:0] tcv, ovv;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // inst0: W4 M15 wrap P1   inst1: W8 M9 wrap P1
  // inst2: W4 M15 sat  P1   inst3: W4 M15 wrap P3
  updown_counter #(.WIDTH(4), .MAX_COUNT(15), .SATURATE(0), .PRESCALE(1)) u0 (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(lv[3:0]), .clear_ovf(clear_ovf), .counter_out(c0), .tc(tcv[0]), .overflow(ovv[0]));
  updown_counter #(.WIDTH(8), .MAX_COUNT(9), .SATURATE(0), .PRESCALE(1)) u1 (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(lv), .clear_ovf(clear_ovf), .counter_out(c1), .tc(tcv[1]), .overflow(ovv[1]));
  updown_counter #(.WIDTH(4), .MAX_COUNT(15), .SATURATE(1), .PRESCALE(1)) u2 (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(lv[3:0]), .clear_ovf(clear_ovf), .counter_out(c2), .tc(tcv[2]), .overflow(ovv[2]));
  updown_counter #(.WIDTH(4), .MAX_COUNT(15), .SATURATE(0), .PRESCALE(3)) u3 (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(lv[3:0]), .clear_ovf(clear_ovf), .counter_out(c3), .tc(tcv[3]), .overflow(ovv[3]));

  // Reference model parameters and state
  int pw[4] = '{4, 8, 4, 4};
  int pm[4] = '{15, 9, 15, 15};
  int psat[4] = '{0, 0, 1, 0};
  int ppre[4] = '{1, 1, 1, 3};
  int m_cnt[4], m_ps[4], m_tc[4], m_ovf[4];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int act_cnt(input int i);
    case (i)
      0: return int'(c0);
      1: return int'(c1);
      2: return int'(c2);
      default: return int'(c3);
    endcase
  endfunction

  task automatic model_step(input int i);
    int v;
    if (reset) begin
      m_cnt[i] = 0; m_ps[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
    end else if (load) begin
      v = int'(lv) % (1 << pw[i]);
      m_cnt[i] = (v > pm[i]) ? pm[i] : v;
      m_ps[i] = 0;
      m_tc[i] = 0;
      if (clear_ovf) m_ovf[i] = 0;
    end else begin
      m_tc[i] = 0;
      if (clear_ovf) m_ovf[i] = 0;
      if (enable) begin
        m_ps[i] = m_ps[i] + 1;
        if (m_ps[i] == ppre[i]) begin
          m_ps[i] = 0;
          if (up_down) begin
            if (m_cnt[i] == pm[i]) begin
              m_tc[i] = 1; m_ovf[i] = 1;
              m_cnt[i] = psat[i] ? pm[i] : 0;
            end else m_cnt[i] = m_cnt[i] + 1;
          end else begin
            if (m_cnt[i] == 0) begin
              m_tc[i] = 1; m_ovf[i] = 1;
              m_cnt[i] = psat[i] ? 0 : pm[i];
            end else m_cnt[i] = m_cnt[i] - 1;
          end
        end
      end
    end
  endtask

  // One clock edge: advance the model with the inputs seen at the edge,
  // then compare every instance against it shortly after the edge.
  task automatic cycle();
    @(posedge clock);
    for (int i = 0; i < 4; i++) model_step(i);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sb%0d cnt", i), act_cnt(i), m_cnt[i]);
      chk($sformatf("sb%0d tc", i), int'(tcv[i]), m_tc[i]);
      chk($sformatf("sb%0d ovf", i), int'(ovv[i]), m_ovf[i]);
    end
  endtask

  task automatic drive(input bit r, input bit e, input bit ud, input bit ld,
                       input int v, input bit clr);
    reset = r; enable = e; up_down = ud; load = ld; lv = 8'(v); clear_ovf = clr;
  endtask

  typedef struct {
    bit rst, en, ud, ld;
    int lv;
    bit clr;
    int ecnt, etc, eovf;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t;
    drive(1, 0, 0, 0, 0, 0);

    // Wrap-around up count on inst0
    for (int k = 0; k < 2; k++) begin
      t = '{rst:1, en:0, ud:0, ld:0, lv:0, clr:0, ecnt:0, etc:0, eovf:0};
      tbl.push_back(t);
    end
    for (int k = 1; k <= 17; k++) begin
      t = '{rst:0, en:1, ud:1, ld:0, lv:0, clr:0, ecnt:k % 16,
            etc:(k == 16) ? 1 : 0, eovf:(k >= 16) ? 1 : 0};
      tbl.push_back(t);
    end
    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].en, tbl[k].ud, tbl[k].ld, tbl[k].lv, tbl[k].clr);
      cycle();
      chk($sformatf("t1 row%0d cnt", k), int'(c0), tbl[k].ecnt);
      chk($sformatf("t1 row%0d tc", k), int'(tcv[0]), tbl[k].etc);
      chk($sformatf("t1 row%0d ovf", k), int'(ovv[0]), tbl[k].eovf);
    end

    // Modulus-10 down count on inst1
    drive(0, 0, 0, 1, 2, 0); cycle(); chk("t2 load2", int'(c1), 2);
    drive(0, 1, 0, 0, 0, 0); cycle(); chk("t2 d1", int'(c1), 1);
    cycle(); chk("t2 d0", int'(c1), 0);
    cycle(); chk("t2 d9", int'(c1), 9); chk("t2 tc9", int'(tcv[1]), 1);
    cycle(); chk("t2 d8", int'(c1), 8); chk("t2 tc8", int'(tcv[1]), 0);
    drive(0, 0, 0, 1, 200, 0); cycle(); chk("t2 clamp", int'(c1), 9);

    // Saturation on inst2, clear vs set in same cycle
    drive(0, 0, 0, 0, 0, 1); cycle(); chk("t3 cleared", int'(ovv[2]), 0);
    drive(0, 0, 0, 1, 14, 0); cycle(); chk("t3 load14", int'(c2), 14);
    drive(0, 1, 1, 0, 0, 0); cycle();
    chk("t3 s1", int'(c2), 15); chk("t3 s1 tc", int'(tcv[2]), 0);
    cycle(); chk("t3 s2", int'(c2), 15); chk("t3 s2 tc", int'(tcv[2]), 1);
    cycle(); chk("t3 s3", int'(c2), 15); chk("t3 s3 tc", int'(tcv[2]), 1);
    drive(0, 1, 1, 0, 0, 1); cycle();
    chk("t3 s4", int'(c2), 15); chk("t3 s4 tc", int'(tcv[2]), 1);
    chk("t3 set wins", int'(ovv[2]), 1);
    drive(0, 0, 1, 0, 0, 1); cycle();
    chk("t3 clear", int'(ovv[2]), 0); chk("t3 tc drop", int'(tcv[2]), 0);

    // Prescaler on inst3
    drive(1, 0, 0, 0, 0, 0); cycle();
    drive(0, 1, 1, 0, 0, 0);
    cycle(); chk("t4 p1", int'(c3), 0);
    cycle(); chk("t4 p2", int'(c3), 0);
    cycle(); chk("t4 p3", int'(c3), 1);
    cycle(); cycle(); chk("t4 mid", int'(c3), 1);
    drive(0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cycle(); chk($sformatf("t4 hold%0d", k), int'(c3), 1);
    end
    drive(0, 1, 1, 0, 0, 0); cycle(); chk("t4 resume", int'(c3), 2);
    cycle(); chk("t4 pre-load", int'(c3), 2);
    drive(0, 1, 1, 1, 5, 0); cycle(); chk("t4 load5", int'(c3), 5);
    drive(0, 1, 1, 0, 0, 0);
    cycle(); chk("t4 l1", int'(c3), 5);
    cycle(); chk("t4 l2", int'(c3), 5);
    cycle(); chk("t4 l3", int'(c3), 6);

    // Reset dominates load/enable
    drive(0, 0, 1, 1, 15, 0); cycle();
    drive(0, 1, 1, 0, 0, 0); cycle(); chk("t5 ovf before", int'(ovv[2]), 1);
    drive(1, 1, 1, 1, 5, 0); cycle();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5 cnt%0d", i), act_cnt(i), 0);
      chk($sformatf("t5 tc%0d", i), int'(tcv[i]), 0);
      chk($sformatf("t5 ovf%0d", i), int'(ovv[i]), 0);
    end

    // Load at the boundary with enable high: no step
    drive(0, 1, 1, 1, 9, 0); cycle();
    chk("t6 ld9", int'(c1), 9); chk("t6 tc a", int'(tcv[1]), 0);
    cycle();
    chk("t6 ld9 again", int'(c1), 9); chk("t6 tc b", int'(tcv[1]), 0);
    chk("t6 ovf", int'(ovv[1]), 0);

    // Randomised run, checked by the model every cycle
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
            1'($urandom), ($urandom_range(0, 9) == 0),
            int'($urandom_range(0, 255)), ($urandom_range(0, 19) == 0));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
